// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC droop-compensation FIR: coefficient set,
// controller states and the accumulator width helper.
package cic_comp_pkg;

  localparam int TAPS_P      = 5;
  localparam int COEF_BITS_P = 8;

  // Coefficients sum to 64, so a shift by 6 gives unity DC gain.
  localparam logic signed [COEF_BITS_P-1:0] COEF [TAPS_P] =
    '{-8'sd2, -8'sd6, 8'sd80, -8'sd6, -8'sd2};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int acc_bits(input int bits, input int coef_bits, input int taps);
    return bits + coef_bits + $clog2(taps);
  endfunction

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation to a
// narrower signed width. One guard bit keeps the rounding add from wrapping.
module round_sat #(
  parameter int IN_BITS  = 21,
  parameter int OUT_BITS = 10,
  parameter int SHIFT    = 6
) (
  input  logic signed [IN_BITS-1:0]  din_i,
  output logic signed [OUT_BITS-1:0] dout_o
);

  localparam int W = IN_BITS + 1;
  localparam logic signed [W-1:0] HALF = W'(2 ** (SHIFT - 1));
  localparam logic signed [W-1:0] MAXV = W'(2 ** (OUT_BITS - 1) - 1);
  localparam logic signed [W-1:0] MINV = W'(-(2 ** (OUT_BITS - 1)));

  function automatic logic signed [W-1:0] round_f(input logic signed [IN_BITS-1:0] x);
    logic signed [W-1:0] r;
    r = $signed({x[IN_BITS-1], x}) + HALF;
    return r >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_BITS-1:0] sat_f(input logic signed [W-1:0] y);
    if (y > MAXV)      return MAXV[OUT_BITS-1:0];
    else if (y < MINV) return MINV[OUT_BITS-1:0];
    else               return y[OUT_BITS-1:0];
  endfunction

  assign dout_o = sat_f(round_f(din_i));

endmodule

// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR behind the CIC decimator: one multiply-accumulate per
// clock over the delay line, then round/saturate and a one-cycle ready strobe.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int BITS      = 10,
  parameter int TAPS      = 5,
  parameter int COEF_BITS = 8,
  parameter int SHIFT     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] stream_in,
  input  logic                   valid,
  output logic signed [BITS-1:0] stream_out,
  output logic                   ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int ACC_BITS  = acc_bits(BITS, COEF_BITS, TAPS);
  localparam int PROD_BITS = BITS + COEF_BITS;
  localparam int IDX_W     = $clog2(TAPS);

  state_e                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic signed [ACC_BITS-1:0]  acc_q;
  logic signed [ACC_BITS-1:0]  acc_d;
  logic signed [BITS-1:0]      tap_q [TAPS];
  logic signed [PROD_BITS-1:0] prod;
  logic signed [BITS-1:0]      rs_out;
  logic signed [BITS-1:0]      out_q;
  logic                        ready_q;
  logic                        ovr_q;

  // Operands widened first so the product is formed at full precision.
  always_comb begin
    prod  = PROD_BITS'(tap_q[idx_q]) * PROD_BITS'(COEF[idx_q]);
    acc_d = acc_q + ACC_BITS'(prod);
  end

  round_sat #(
    .IN_BITS (ACC_BITS),
    .OUT_BITS(BITS),
    .SHIFT   (SHIFT)
  ) u_round_sat (
    .din_i (acc_q),
    .dout_o(rs_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            for (int k = TAPS - 1; k > 0; k--) tap_q[k] <= tap_q[k-1];
            tap_q[0] <= stream_in;
            acc_q    <= '0;
            idx_q    <= '0;
            state_q  <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(TAPS - 1)) state_q <= OUT;
        end
        OUT: begin
          out_q   <= rs_out;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Samples arriving mid-computation are dropped but remembered.
      if (valid && state_q != IDLE) ovr_q <= 1'b1;
    end
  end

  assign stream_out = out_q;
  assign ready      = ready_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: the driver predicts each filtered sample
// from an integer convolution model; a negedge monitor checks every ready strobe.
module tb_cic_comp_fir;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic signed [9:0] stream_in = '0;
  logic signed [9:0] stream_out;
  logic              ready;
  logic              busy;
  logic              overrun;

  cic_comp_fir #(
    .BITS     (10),
    .TAPS     (5),
    .COEF_BITS(8),
    .SHIFT    (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stream_in (stream_in),
    .valid     (valid),
    .stream_out(stream_out),
    .ready     (ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  localparam int CM [5] = '{-2, -6, 80, -6, -2};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = -100;
  bit exp_ovr = 1'b0;
  int hist [5] = '{0, 0, 0, 0, 0};
  int exp_q [$];
  bit prev_ready = 1'b0;
  int popped;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_y();
    int s;
    int y;
    s = 0;
    for (int k = 0; k < 5; k++) s += hist[k] * CM[k];
    y = floor_div(s + 32, 64);
    if (y > 511) y = 511;
    if (y < -512) y = -512;
    return y;
  endfunction

  // A sample is accepted only if at least 7 edges separate it from the last accepted one.
  task automatic issue(input int s);
    int e;
    stream_in = 10'(s);
    valid = 1'b1;
    e = cyc + 1;
    if (e - last_acc >= 7) begin
      last_acc = e;
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      exp_q.push_back(model_y());
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int gap);
    issue(s);
    tick();
    valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        check("ready_pulse_width", int'(prev_ready), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got stream_out=%0d expected no output (cycle %0d)",
                   stream_out, cyc);
        end else begin
          popped = exp_q.pop_front();
          check("stream_out", int'(stream_out), popped);
        end
      end
      prev_ready = ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_stream_out", int'(stream_out), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Impulse: coefficient readout
    send(64, 8);
    repeat (9) send(0, 8);
    drain();

    // DC: settles to the input value
    repeat (8) send(100, 8);
    drain();

    // Full-scale alternating input: must clamp, not wrap
    repeat (8) begin
      send(-512, 8);
      send(511, 8);
    end
    drain();
    repeat (3) tick();

    // Latency and busy window
    issue(37);
    tick();
    valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("lat_busy_%0d", j), int'(busy), (j <= 5) ? 1 : 0);
      check($sformatf("lat_ready_%0d", j), int'(ready), (j == 6) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    drain();
    repeat (3) tick();

    // Overrun: second sample three edges later is dropped
    check("ovr_before", int'(overrun), 0);
    send(200, 3);
    send(300, 8);
    check("ovr_set", int'(overrun), int'(exp_ovr));
    repeat (5) send(0, 8);
    drain();
    check("ovr_sticky", int'(overrun), 1);

    // Randomized traffic, occasionally too fast
    repeat (40) send(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(5, 10)));
    drain();
    check("ovr_random", int'(overrun), int'(exp_ovr));
    repeat (8) tick();

    // Reset in the middle of a computation
    send(64, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) hist[k] = 0;
    last_acc = -100;
    exp_ovr = 1'b0;
    check("midrst_stream_out", int'(stream_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_ready", int'(ready), 0);
    repeat (10) tick();
    send(64, 8);
    repeat (9) send(0, 8);
    drain();
    check("final_overrun", int'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
